// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, disparity width and the stage-1
// transition-minimisation helpers used by every channel.
package tmds_pkg;

  localparam int CNT_W = 5;

  typedef logic [9:0] tmds_sym_t;
  typedef logic signed [CNT_W-1:0] disp_t;

  // Disparity decision classes applied in stage 2.
  typedef enum logic [1:0] {
    DISP_BAL  = 2'd0,
    DISP_INV  = 2'd1,
    DISP_KEEP = 2'd2
  } disp_case_e;

  localparam tmds_sym_t CTRL_TOKEN_00 = 10'b1101010100;
  localparam tmds_sym_t CTRL_TOKEN_01 = 10'b0010101011;
  localparam tmds_sym_t CTRL_TOKEN_10 = 10'b0101010100;
  localparam tmds_sym_t CTRL_TOKEN_11 = 10'b1010101011;

  localparam disp_t DISP_ZERO  = 5'sd0;
  localparam disp_t DISP_TWO   = 5'sd2;
  localparam disp_t DISP_EIGHT = 5'sd8;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // XNOR chain when the byte is ones-heavy (ties broken by bit 0), XOR chain
  // otherwise; bit 8 records which chain was used (1 = XOR).
  function automatic logic [8:0] minimise(input logic [7:0] d);
    logic [3:0] nd;
    logic       use_xnor;
    logic [8:0] qm;
    nd       = popcount8(d);
    use_xnor = (nd > 4'd4) || ((nd == 4'd4) && !d[0]);
    qm       = '0;
    qm[0]    = d[0];
    for (int i = 1; i < 8; i++) begin
      qm[i] = use_xnor ? ~(d[i] ^ qm[i-1]) : (d[i] ^ qm[i-1]);
    end
    qm[8] = ~use_xnor;
    return qm;
  endfunction

  function automatic tmds_sym_t ctrl_token(input logic [1:0] c);
    tmds_sym_t t;
    case (c)
      2'b00:   t = CTRL_TOKEN_00;
      2'b01:   t = CTRL_TOKEN_01;
      2'b10:   t = CTRL_TOKEN_10;
      default: t = CTRL_TOKEN_11;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/tmds_encoder_multi_if.sv
// Video-side bundle of the TMDS encoder: enable, pixel bytes, control bits
// and the encoded symbols returned by the encoder.
interface tmds_encoder_multi_if #(
  parameter int NUM_CH = 3
);
  logic                   ve;
  logic [8*NUM_CH-1:0]    data;
  logic [2*NUM_CH-1:0]    control;
  logic [10*NUM_CH-1:0]   tmds;

  modport master (
    output ve,
    output data,
    output control,
    input  tmds
  );

  modport slave (
    input  ve,
    input  data,
    input  control,
    output tmds
  );
endinterface

// File: rtl/tmds_channel.sv
// One TMDS lane: registered transition minimisation followed by a registered
// DC-balancing stage with its own running disparity.
module tmds_channel
  import tmds_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  tmds_encoder_multi_if.slave  bus
);

  logic [8:0] qm_p1_d;
  logic [3:0] n1_p1_d;
  logic [8:0] qm_p1_q;
  logic [3:0] n1_p1_q;
  logic       ve_p1_q;
  logic [1:0] ctrl_p1_q;

  assign qm_p1_d = minimise(bus.data[7:0]);
  assign n1_p1_d = popcount8(qm_p1_d[7:0]);

  // Stage 1: minimised word, its ones count, and the matching ve/control
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      qm_p1_q   <= '0;
      n1_p1_q   <= '0;
      ve_p1_q   <= 1'b0;
      ctrl_p1_q <= 2'b00;
    end else begin
      qm_p1_q   <= qm_p1_d;
      n1_p1_q   <= n1_p1_d;
      ve_p1_q   <= bus.ve;
      ctrl_p1_q <= bus.control[1:0];
    end
  end

  disp_t      n1_s;
  disp_t      n0_s;
  disp_t      diff_s;
  disp_t      cnt_d;
  disp_t      cnt_q;
  disp_case_e case_s;
  tmds_sym_t  sym_d;
  tmds_sym_t  sym_p2_q;

  always_comb begin
    n1_s   = disp_t'({1'b0, n1_p1_q});
    n0_s   = DISP_EIGHT - n1_s;
    diff_s = n1_s - n0_s;

    if ((cnt_q == DISP_ZERO) || (n1_s == n0_s)) begin
      case_s = DISP_BAL;
    end else if (((cnt_q > DISP_ZERO) && (n1_s > n0_s)) ||
                 ((cnt_q < DISP_ZERO) && (n0_s > n1_s))) begin
      case_s = DISP_INV;
    end else begin
      case_s = DISP_KEEP;
    end

    sym_d = CTRL_TOKEN_00;
    cnt_d = cnt_q;
    if (!ve_p1_q) begin
      sym_d = ctrl_token(ctrl_p1_q);
      cnt_d = DISP_ZERO;
    end else begin
      case (case_s)
        DISP_BAL: begin
          sym_d = {~qm_p1_q[8], qm_p1_q[8],
                   qm_p1_q[8] ? qm_p1_q[7:0] : ~qm_p1_q[7:0]};
          cnt_d = qm_p1_q[8] ? (cnt_q + diff_s) : (cnt_q - diff_s);
        end
        DISP_INV: begin
          sym_d = {1'b1, qm_p1_q[8], ~qm_p1_q[7:0]};
          cnt_d = cnt_q - diff_s + (qm_p1_q[8] ? DISP_TWO : DISP_ZERO);
        end
        DISP_KEEP: begin
          sym_d = {1'b0, qm_p1_q[8], qm_p1_q[7:0]};
          cnt_d = cnt_q + diff_s - (qm_p1_q[8] ? DISP_ZERO : DISP_TWO);
        end
        default: begin
          sym_d = CTRL_TOKEN_00;
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  // Stage 2: output symbol and running disparity
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sym_p2_q <= CTRL_TOKEN_00;
      cnt_q    <= DISP_ZERO;
    end else begin
      sym_p2_q <= sym_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.tmds = sym_p2_q;

endmodule

// File: rtl/tmds_encoder_multi.sv
// NUM_CH independent TMDS lanes sharing one pixel clock; each lane slices its
// byte, control pair and symbol out of the flat buses.
module tmds_encoder_multi
  import tmds_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 ve_in,
  input  logic [8*NUM_CH-1:0]  data_in,
  input  logic [2*NUM_CH-1:0]  control_in,
  output logic [10*NUM_CH-1:0] tmds_out
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    tmds_encoder_multi_if #(.NUM_CH(1)) ch_if ();
    tmds_sym_t sym;

    assign ch_if.ve      = ve_in;
    assign ch_if.data    = data_in[8*k +: 8];
    assign ch_if.control = control_in[2*k +: 2];
    assign sym           = ch_if.tmds;
    assign tmds_out[10*k +: 10] = sym;

    tmds_channel u_ch (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (ch_if.slave)
    );
  end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Scoreboard bench for the 3-lane TMDS encoder: directed vectors with
// hand-derived symbols, then random traffic against a behavioural model.
module tb_tmds_encoder_multi;
  import tmds_pkg::*;

  localparam int NCH = 3;
  localparam logic [29:0] ALL_354 = {3{10'h354}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tmds_encoder_multi_if #(.NUM_CH(NCH)) bus ();

  tmds_encoder_multi #(.NUM_CH(NCH)) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .ve_in      (bus.ve),
    .data_in    (bus.data),
    .control_in (bus.control),
    .tmds_out   (bus.tmds)
  );

  logic signed [4:0] dcnt [NCH];
  assign dcnt[0] = dut.g_ch[0].u_ch.cnt_q;
  assign dcnt[1] = dut.g_ch[1].u_ch.cnt_q;
  assign dcnt[2] = dut.g_ch[2].u_ch.cnt_q;

  typedef struct {
    int          due;
    logic [29:0] sym;
    logic [14:0] cnt;
    bit          chk_cnt;
    bit          chk_dec;
    logic        ve;
    logic [23:0] data;
    logic [5:0]  ctrl;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   fin_req = 1'b0;
  bit   fin_done = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [7:0] dec8(input logic [9:0] s);
    logic [7:0] v;
    logic [7:0] d;
    v    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = v[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
    end
    return d;
  endfunction

  function automatic int decc(input logic [9:0] s);
    case (s)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_enc(input logic [7:0] d, input int cin,
                           output logic [9:0] q, output int cout);
    logic [8:0] m;
    int n1;
    int n0;
    m    = '0;
    m[0] = d[0];
    if ($countones(d) > 4 || ($countones(d) == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) m[i] = m[i-1] ~^ d[i];
      m[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) m[i] = m[i-1] ^ d[i];
      m[8] = 1'b1;
    end
    n1 = $countones(m[7:0]);
    n0 = 8 - n1;
    if (cin == 0 || n1 == n0) begin
      q    = {~m[8], m[8], (m[8] ? m[7:0] : ~m[7:0])};
      cout = m[8] ? cin + n1 - n0 : cin + n0 - n1;
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      q    = {1'b1, m[8], ~m[7:0]};
      cout = cin + (m[8] ? 2 : 0) + n0 - n1;
    end else begin
      q    = {1'b0, m[8], m[7:0]};
      cout = cin - (m[8] ? 0 : 2) + n1 - n0;
    end
  endtask

  task automatic push(input int lat, input logic [29:0] sym, input logic [14:0] cnt,
                      input bit cc, input bit dc, input string tag);
    exp_t e;
    e.due     = cyc + lat;
    e.sym     = sym;
    e.cnt     = cnt;
    e.chk_cnt = cc;
    e.chk_dec = dc;
    e.ve      = bus.ve;
    e.data    = bus.data;
    e.ctrl    = bus.control;
    e.tag     = tag;
    sbq.push_back(e);
  endtask

  task automatic drv(input logic ve, input logic [23:0] data, input logic [5:0] ctrl);
    bus.ve      = ve;
    bus.data    = data;
    bus.control = ctrl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops every expectation whose output slot has arrived.
  initial begin
    exp_t me;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() != 0 && sbq[0].due <= cyc) begin
        me = sbq.pop_front();
        if (me.due != cyc) begin
          checks++;
          errors++;
          $display("FAIL %s slot: expected at cycle %0d, reached at %0d", me.tag, me.due, cyc);
        end else begin
          for (int k = 0; k < NCH; k++) begin
            act = bus.tmds[10*k +: 10];
            checks++;
            if (act !== me.sym[10*k +: 10]) begin
              errors++;
              $display("FAIL %s ch%0d sym: got %h expected %h", me.tag, k, act, me.sym[10*k +: 10]);
            end
            if (me.chk_cnt) begin
              checks++;
              if (dcnt[k] !== me.cnt[5*k +: 5] || dcnt[k] > 8 || dcnt[k] < -8) begin
                errors++;
                $display("FAIL %s ch%0d cnt: got %0d expected %0d", me.tag, k,
                         dcnt[k], $signed(me.cnt[5*k +: 5]));
              end
            end
            if (me.chk_dec) begin
              checks++;
              if (me.ve && dec8(act) !== me.data[8*k +: 8]) begin
                errors++;
                $display("FAIL %s ch%0d decode: got %h expected %h", me.tag, k,
                         dec8(act), me.data[8*k +: 8]);
              end else if (!me.ve && decc(act) != int'(me.ctrl[2*k +: 2])) begin
                errors++;
                $display("FAIL %s ch%0d ctrl decode: got %0d expected %0d", me.tag, k,
                         decc(act), me.ctrl[2*k +: 2]);
              end
            end
          end
        end
      end
      if (fin_req && !fin_done) begin
        checks++;
        if (sbq.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d expectations never reached, need 0", sbq.size());
        end
        fin_done = 1'b1;
      end
    end
  end

  initial begin
    logic [9:0]  bal_s [3];
    logic [4:0]  bal_c [3];
    int          mcnt [NCH];
    logic [29:0] esym;
    logic [14:0] ecnt;
    logic [9:0]  q;
    int          cn;
    logic [31:0] r;

    bal_s = '{10'h100, 10'h3FF, 10'h100};
    bal_c = '{5'h18, 5'h02, 5'h1A};

    drv(1'b1, 24'hAAAAAA, 6'b000000);
    rst = 1'b1;
    push(1, ALL_354, 15'd0, 1'b1, 1'b0, "reset1");
    tick();
    push(1, ALL_354, 15'd0, 1'b1, 1'b0, "reset2");
    tick();
    rst = 1'b0;
    drv(1'b0, 24'h000000, 6'b111001);
    push(1, ALL_354, 15'd0, 1'b1, 1'b0, "flush");
    push(2, {10'h2AB, 10'h154, 10'h0AB}, 15'd0, 1'b1, 1'b1, "ctrl");

    for (int i = 0; i < 3; i++) begin
      tick();
      drv(1'b1, {8'h10, 8'h10, 8'h00}, 6'd0);
      push(2, {10'h1F0, 10'h1F0, bal_s[i]}, {5'd0, 5'd0, bal_c[i]}, 1'b1, 1'b1, "dcbal");
    end

    tick();
    drv(1'b0, 24'h000000, 6'd0);
    push(2, ALL_354, 15'd0, 1'b1, 1'b1, "ctrl00");
    tick();
    drv(1'b1, 24'hFFFFFF, 6'd0);
    push(2, {3{10'h200}}, {3{5'h18}}, 1'b1, 1'b1, "xnor");
    tick();
    drv(1'b0, 24'h000000, 6'd0);
    push(2, ALL_354, 15'd0, 1'b1, 1'b1, "ctrl00b");
    tick();
    drv(1'b1, {8'h10, 8'hFF, 8'h00}, 6'd0);
    push(2, {10'h1F0, 10'h200, 10'h100}, {5'h00, 5'h18, 5'h18}, 1'b1, 1'b1, "mixed1");
    tick();
    push(2, {10'h1F0, 10'h0FF, 10'h3FF}, {5'h00, 5'h1E, 5'h02}, 1'b1, 1'b1, "mixed2");

    // This byte is overtaken by the reset on the following edge.
    tick();
    drv(1'b1, 24'h555555, 6'd0);
    tick();
    rst = 1'b1;
    drv(1'b1, 24'hAAAAAA, 6'd0);
    push(1, ALL_354, 15'd0, 1'b1, 1'b0, "midrst");
    tick();
    rst = 1'b0;
    drv(1'b1, 24'h000000, 6'd0);
    push(1, ALL_354, 15'd0, 1'b1, 1'b0, "postrst");
    push(2, {3{10'h100}}, {3{5'h18}}, 1'b1, 1'b1, "firstdata");
    tick();
    drv(1'b0, 24'h000000, 6'd0);
    push(2, ALL_354, 15'd0, 1'b1, 1'b1, "ctrlsync");
    for (int k = 0; k < NCH; k++) mcnt[k] = 0;

    for (int n = 0; n < 10000; n++) begin
      tick();
      r = $urandom();
      drv($urandom_range(0, 9) != 0, r[23:0], r[29:24]);
      for (int k = 0; k < NCH; k++) begin
        if (bus.ve) begin
          model_enc(bus.data[8*k +: 8], mcnt[k], q, cn);
          mcnt[k] = cn;
        end else begin
          q       = ctrl_token(bus.control[2*k +: 2]);
          mcnt[k] = 0;
        end
        esym[10*k +: 10] = q;
        ecnt[5*k +: 5]   = mcnt[k][4:0];
      end
      push(2, esym, ecnt, 1'b1, 1'b1, "rand");
    end

    for (int i = 0; i < 4; i++) tick();
    fin_req = 1'b1;
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
